// File: rtl/ctl_pkg.sv
// Shared types and default character constants for the UART command queue.
// The opcode is a single bit so each queue entry costs one flop.
package ctl_pkg;

    typedef enum logic {
        OP_INCR = 1'b0,
        OP_DECR = 1'b1
    } op_t;

    localparam logic [7:0] DEF_INCR_CHAR = 8'h31;  // '1'
    localparam logic [7:0] DEF_DECR_CHAR = 8'h32;  // '2'
    localparam logic [7:0] DEF_CLR_CHAR  = 8'h63;  // 'c'
    localparam logic [7:0] DEF_HERE_CHAR = 8'h68;  // 'h'
    localparam logic [7:0] DEF_NAK_CHAR  = 8'h21;  // '!'

endpackage

// File: rtl/ctl_cmd_queue_if.sv
// Bundle of the UART byte paths and the control-consumer handshake.
// The slave modport is the queue block; the master modport is its environment.
interface ctl_cmd_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic [DATA_W-1:0]          rx_data;
    logic                       rx_valid;
    logic                       rx_ready;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic                       ctl_valid;
    logic                       ctl_ready;
    logic                       ctl_incr;
    logic                       ctl_decr;
    logic [$clog2(DEPTH+1)-1:0] q_level;

    modport slave (
        input  rx_data, rx_valid, tx_ready, ctl_ready,
        output rx_ready, tx_data, tx_valid, ctl_valid, ctl_incr, ctl_decr, q_level
    );

    modport master (
        output rx_data, rx_valid, tx_ready, ctl_ready,
        input  rx_ready, tx_data, tx_valid, ctl_valid, ctl_incr, ctl_decr, q_level
    );
endinterface

// File: rtl/ctl_cmd_fifo.sv
// DEPTH x 1-bit opcode FIFO with push/pop/flush and an occupancy count.
// Flush dominates any same-cycle push or pop.
module ctl_cmd_fifo
    import ctl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  op_t                        push_op,
    input  logic                       pop,
    input  logic                       flush,
    output op_t                        head_op,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    op_t              mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && (level != LVL_W'(DEPTH));
    assign do_pop  = pop && (level != '0);
    assign head_op = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only read once level says they
    // were written, so resetting them would just add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_op;
    end
endmodule

// File: rtl/ctl_cmd_queue.sv
// Decodes received UART bytes into queued incr/decr commands and produces
// one reply byte per accepted byte (echo, NAK, clear ack or 'here').
module ctl_cmd_queue
    import ctl_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 4,
    parameter logic [DATA_W-1:0] INCR_CHAR = DATA_W'(DEF_INCR_CHAR),
    parameter logic [DATA_W-1:0] DECR_CHAR = DATA_W'(DEF_DECR_CHAR),
    parameter logic [DATA_W-1:0] CLR_CHAR  = DATA_W'(DEF_CLR_CHAR),
    parameter logic [DATA_W-1:0] HERE_CHAR = DATA_W'(DEF_HERE_CHAR),
    parameter logic [DATA_W-1:0] NAK_CHAR  = DATA_W'(DEF_NAK_CHAR)
) (
    input  logic            clk,
    input  logic            rst_n,
    ctl_cmd_queue_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic              accept;
    logic              is_cmd;
    logic              is_clr;
    logic              full;
    logic              push;
    logic              pop;
    op_t               rx_op;
    op_t               head_op;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] reply;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_valid_q;

    // A single reply slot: no new byte is taken while a reply is outstanding.
    assign accept = bus.rx_valid && !tx_valid_q;
    assign is_cmd = (bus.rx_data == INCR_CHAR) || (bus.rx_data == DECR_CHAR);
    assign is_clr = (bus.rx_data == CLR_CHAR);
    assign full   = (level == LVL_W'(DEPTH));
    assign rx_op  = (bus.rx_data == DECR_CHAR) ? OP_DECR : OP_INCR;
    assign push   = accept && is_cmd && !full;
    assign pop    = bus.ctl_valid && bus.ctl_ready;

    // NOTE: reply gets a default before the branches so no latch is inferred.
    always_comb begin
        reply = HERE_CHAR;
        if (is_cmd) begin
            reply = full ? NAK_CHAR : bus.rx_data;
        end else if (is_clr) begin
            reply = CLR_CHAR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (accept) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= reply;
        end else if (tx_valid_q && bus.tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    ctl_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .push_op (rx_op),
        .pop     (pop),
        .flush   (accept && is_clr),
        .head_op (head_op),
        .level   (level)
    );

    assign bus.rx_ready  = !tx_valid_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.q_level   = level;
    assign bus.ctl_valid = (level != '0);
    assign bus.ctl_incr  = bus.ctl_valid && (head_op == OP_INCR);
    assign bus.ctl_decr  = bus.ctl_valid && (head_op == OP_DECR);
endmodule

// File: doc/ctl_cmd_queue.md
CTL_CMD_QUEUE -- requirements
Module: ctl_cmd_queue

Interface
REQ-001 Parameter DATA_W, default 8, width of UART byte path.
REQ-002 Parameter DEPTH, default 4, command queue entries; power of 2, >= 2.
REQ-003 Parameter INCR_CHAR, default 8'h31 ('1'), increment command byte.
REQ-004 Parameter DECR_CHAR, default 8'h32 ('2'), decrement command byte.
REQ-005 Parameter CLR_CHAR, default 8'h63 ('c'), flush-queue command byte.
REQ-006 Parameter HERE_CHAR, default 8'h68 ('h'), reply byte for unrecognised input.
REQ-007 Parameter NAK_CHAR, default 8'h21 ('!'), reply byte for a command dropped on a full queue.
REQ-008 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-009 clk  in  1  system clock; all state changes on rising edge.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 rx_data  in  DATA_W  received byte from UART receiver.
REQ-012 rx_valid  in  1  rx_data valid.
REQ-013 rx_ready  out  1  block can accept rx_data this cycle.
REQ-014 tx_data  out  DATA_W  reply byte to UART transmitter.
REQ-015 tx_valid  out  1  reply byte pending.
REQ-016 tx_ready  in  1  transmitter accepts tx_data this cycle.
REQ-017 ctl_valid  out  1  head command pending for control consumer.
REQ-018 ctl_ready  in  1  consumer accepts head command.
REQ-019 ctl_incr  out  1  head command is increment.
REQ-020 ctl_decr  out  1  head command is decrement.
REQ-021 q_level  out  $clog2(DEPTH+1)  queued command count, 0..DEPTH.

Function
REQ-022 rx byte accepted on a cycle with rx_valid && rx_ready; rx_ready = !tx_valid (one reply slot; no byte accepted while a reply is pending).
REQ-023 Accepted INCR_CHAR/DECR_CHAR with q_level < DEPTH: push opcode, reply = the received byte (echo).
REQ-024 Accepted INCR_CHAR/DECR_CHAR with q_level == DEPTH (sampled before any same-cycle pop): no push, reply = NAK_CHAR.
REQ-025 Accepted CLR_CHAR: queue emptied next cycle (a same-cycle pop is discarded too), reply = CLR_CHAR.
REQ-026 Accepted any other byte: queue unchanged, reply = HERE_CHAR.
REQ-027 Reply latency: tx_valid high the cycle after acceptance; tx_data and tx_valid held stable until tx_valid && tx_ready, then tx_valid low next cycle.
REQ-028 Queue latency: command accepted at cycle N with empty queue gives ctl_valid high at N+1.
REQ-029 ctl_valid = (q_level != 0); ctl_incr/ctl_decr decode the head opcode, exactly one high when ctl_valid, both low otherwise.
REQ-030 Pop on ctl_valid && ctl_ready; head outputs held stable while ctl_valid && !ctl_ready.
REQ-031 Simultaneous push and pop on a non-full queue: q_level unchanged, order preserved (FIFO).
REQ-032 Read/write pointers wrap modulo DEPTH; q_level never exceeds DEPTH nor underflows.

Reset
REQ-033 rst_n low: queue empty, q_level = 0, ctl_valid/ctl_incr/ctl_decr = 0, tx_valid = 0, tx_data = 0, rx_ready = 1 on release.
REQ-034 Reset mid-reply or mid-queue discards pending reply and all queued commands; no partial output after release.

Structure
REQ-035 Shared package ctl_pkg holds the opcode type (OP_INCR, OP_DECR) and the default command/reply character constants.
REQ-036 Queue storage in one sub-module ctl_cmd_fifo (DEPTH x 1-bit opcode, push/pop/flush, level output); reply register and byte decode in ctl_cmd_queue.

Verification
REQ-037 Reset, then '1' with ctl_ready=1, tx_ready=1 -> tx_data 8'h31 one cycle after accept; one ctl_incr pulse; q_level 1 then 0.
REQ-038 ctl_ready=0, send '1','2','1','2','1' -> replies 31,32,31,32,21; q_level = 4; release ctl_ready -> incr,decr,incr,decr in order.
REQ-039 Send 'x' (8'h78) -> tx_data 8'h68, q_level unchanged, ctl_valid stays low.
REQ-040 tx_ready=0 after one reply -> rx_ready low, second byte not accepted until tx_ready pulse; tx_data stable throughout.
REQ-041 Queue holds 3, send 'c' while ctl_ready=1 -> reply 8'h63, q_level 0 next cycle, no further ctl_valid.
REQ-042 Assert rst_n low with full queue and pending reply -> all outputs at reset values, first post-reset '2' yields ctl_decr only.
